// File: rtl/fifo_chk_if.sv
// Observation bus of the FIFO under check: its reset, requests, data and status.
// The FIFO side (or its stand-in) drives through master; the checker samples through slave.
interface fifo_chk_if #(
    parameter int FIFO_WIDTH = 16
);
    logic                  mon_rst_n;
    logic                  mon_wr_en;
    logic                  mon_rd_en;
    logic [FIFO_WIDTH-1:0] mon_data_in;
    logic [FIFO_WIDTH-1:0] mon_data_out;
    logic                  mon_wr_ack;
    logic                  mon_overflow;
    logic                  mon_underflow;
    logic                  mon_full;
    logic                  mon_almostfull;
    logic                  mon_empty;
    logic                  mon_almostempty;

    modport master (
        output mon_rst_n, mon_wr_en, mon_rd_en, mon_data_in, mon_data_out,
        output mon_wr_ack, mon_overflow, mon_underflow,
        output mon_full, mon_almostfull, mon_empty, mon_almostempty
    );

    modport slave (
        input mon_rst_n, mon_wr_en, mon_rd_en, mon_data_in, mon_data_out,
        input mon_wr_ack, mon_overflow, mon_underflow,
        input mon_full, mon_almostfull, mon_empty, mon_almostempty
    );
endinterface

// File: rtl/fifo_chk.sv
// Cycle-accurate FIFO checker: a reference FIFO model predicts every observed output and
// pass/fail cycles are counted. Define FIRST_ERR_CAPTURE_EN to build the first-error capture.
module fifo_chk #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    fifo_chk_if.slave             mon,
    input  logic                  clr,
    output logic [CNT_W-1:0]      correct_cnt,
    output logic [CNT_W-1:0]      error_cnt,
    output logic [7:0]            err_sticky,
    output logic [7:0]            first_err_code,
    output logic [FIFO_WIDTH-1:0] first_err_exp
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(FIFO_DEPTH);

    // Registered-output predictions, compared on the edge after they are formed.
    typedef struct packed {
        logic                  wr_ack;
        logic                  overflow;
        logic                  underflow;
        logic                  dvld;
        logic [FIFO_WIDTH-1:0] data;
    } pred_t;

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [OCC_W-1:0]      count;
    pred_t                 pred;

    logic       model_full, model_afull, model_empty, model_aempty;
    logic       wr_acc, rd_acc;
    logic       checked, fail;
    logic [7:0] miss;

    assign model_full   = (count == DEPTH_C);
    assign model_afull  = (count == DEPTH_C - 1'b1);
    assign model_empty  = (count == '0);
    assign model_aempty = (count == OCC_W'(1));

    assign wr_acc  = mon.mon_wr_en && !model_full;
    assign rd_acc  = mon.mon_rd_en && !model_empty;
    assign checked = mon.mon_rst_n;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        miss    = '0;
        miss[0] = pred.dvld && (mon.mon_data_out != pred.data);
        miss[1] = mon.mon_wr_ack      != pred.wr_ack;
        miss[2] = mon.mon_overflow    != pred.overflow;
        miss[3] = mon.mon_underflow   != pred.underflow;
        miss[4] = mon.mon_full        != model_full;
        miss[5] = mon.mon_almostfull  != model_afull;
        miss[6] = mon.mon_empty       != model_empty;
        miss[7] = mon.mon_almostempty != model_aempty;
    end

    assign fail = checked && (miss != '0);

    // NOTE: the model memory has no reset; count and pointers alone define its valid contents.
    always_ff @(posedge clk) begin
        if (!rst && mon.mon_rst_n && wr_acc) begin
            mem[wr_ptr] <= mon.mon_data_in;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every block sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || !mon.mon_rst_n) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            pred   <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            pred.wr_ack    <= wr_acc;
            pred.overflow  <= mon.mon_wr_en && model_full;
            pred.underflow <= mon.mon_rd_en && model_empty;
            pred.dvld      <= rd_acc;
            pred.data      <= mem[rd_ptr];
        end
    end

    // Saturating pass/fail counters; a mismatch in a clr cycle is dropped.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            correct_cnt <= '0;
            error_cnt   <= '0;
            err_sticky  <= '0;
        end else if (checked) begin
            if (!fail) begin
                if (correct_cnt != '1) correct_cnt <= correct_cnt + 1'b1;
            end else begin
                if (error_cnt != '1) error_cnt <= error_cnt + 1'b1;
                err_sticky <= err_sticky | miss;
            end
        end
    end

`ifdef FIRST_ERR_CAPTURE_EN
    // A failing vector is never zero, so a non-zero code doubles as the "captured" flag.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            first_err_code <= '0;
            first_err_exp  <= '0;
        end else if (fail && (first_err_code == '0)) begin
            first_err_code <= miss;
            first_err_exp  <= miss[0] ? pred.data : '0;
        end
    end
`else
    assign first_err_code = '0;
    assign first_err_exp  = '0;
`endif

endmodule

// File: tb/tb_fifo_chk.sv
// Bench for fifo_chk: a queue-based FIFO stand-in drives the observation bus with planted
// faults, and a scoreboard derives the expected counters from the faults it planted.
module tb_fifo_chk;
    localparam int W    = 16;
    localparam int D    = 8;
    localparam int CW   = 6;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          clr;
    logic [CW-1:0] correct_cnt, error_cnt;
    logic [7:0]    err_sticky, first_err_code;
    logic [W-1:0]  first_err_exp;

    fifo_chk_if #(.FIFO_WIDTH(W)) mon ();

    fifo_chk #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .CNT_W(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .mon            (mon),
        .clr            (clr),
        .correct_cnt    (correct_cnt),
        .error_cnt      (error_cnt),
        .err_sticky     (err_sticky),
        .first_err_code (first_err_code),
        .first_err_exp  (first_err_exp)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // FIFO stand-in: contents as a queue plus its registered status outputs.
    logic [W-1:0] q[$];
    bit           r_wr_ack, r_ovf, r_udf, r_dvld;
    logic [W-1:0] r_dout;

    // Scoreboard of what the checker should report.
    int           sb_corr, sb_err;
    logic [7:0]   sb_sticky, sb_code;
    logic [W-1:0] sb_fexp;
    bit           sb_capt;

    task automatic clear_sb();
        sb_corr = 0; sb_err = 0; sb_sticky = '0; sb_code = '0; sb_fexp = '0; sb_capt = 0;
    endtask

    task automatic clear_fifo();
        q.delete();
        r_wr_ack = 0; r_ovf = 0; r_udf = 0; r_dvld = 0; r_dout = '0;
    endtask

    // One cycle, entered and left at a falling edge. fmask bit i corrupts the observed output
    // of mismatch bit i (data_out is replaced by fdata, the others are inverted).
    task automatic step(input bit wr, input bit rd, input logic [W-1:0] din, input bit mrst_n,
                        input bit clr_i, input logic [7:0] fmask, input logic [W-1:0] fdata);
        int         n;
        logic [7:0] vec;
        bit         wa, ra;
        n = q.size();
        mon.mon_rst_n       = mrst_n;
        mon.mon_wr_en       = wr;
        mon.mon_rd_en       = rd;
        mon.mon_data_in     = din;
        clr                 = clr_i;
        mon.mon_data_out    = fmask[0] ? fdata : r_dout;
        mon.mon_wr_ack      = r_wr_ack ^ fmask[1];
        mon.mon_overflow    = r_ovf    ^ fmask[2];
        mon.mon_underflow   = r_udf    ^ fmask[3];
        mon.mon_full        = (n == D)     ^ fmask[4];
        mon.mon_almostfull  = (n == D - 1) ^ fmask[5];
        mon.mon_empty       = (n == 0)     ^ fmask[6];
        mon.mon_almostempty = (n == 1)     ^ fmask[7];

        vec = fmask;
        if (!r_dvld || (fdata == r_dout)) vec[0] = 1'b0;
        if (clr_i) begin
            clear_sb();
        end else if (mrst_n) begin
            if (vec == '0) begin
                if (sb_corr < CMAX) sb_corr++;
            end else begin
                if (sb_err < CMAX) sb_err++;
                sb_sticky |= vec;
                if (!sb_capt) begin
                    sb_capt = 1;
                    sb_code = vec;
                    sb_fexp = vec[0] ? r_dout : '0;
                end
            end
        end

        @(posedge clk);
        if (!mrst_n) begin
            clear_fifo();
        end else begin
            wa = wr && (n != D);
            ra = rd && (n != 0);
            r_wr_ack = wa;
            r_ovf    = wr && (n == D);
            r_udf    = rd && (n == 0);
            r_dvld   = ra;
            if (ra) r_dout = q.pop_front();
            if (wa) q.push_back(din);
        end
        @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, " correct_cnt"}, 32'(correct_cnt), 32'd0);
        check({tag, " error_cnt"}, 32'(error_cnt), 32'd0);
        check({tag, " err_sticky"}, 32'(err_sticky), 32'd0);
        check({tag, " first_err_code"}, 32'(first_err_code), 32'd0);
        check({tag, " first_err_exp"}, 32'(first_err_exp), 32'd0);
    endtask

    // Reset is asserted with a pending clr, a low observed reset and a planted fault on the bus,
    // all of which it must override.
    task automatic do_reset();
        rst = 1'b1;
        clr = 1'b1;
        mon.mon_rst_n = 1'b0;
        mon.mon_wr_en = 1'b1;
        mon.mon_rd_en = 1'b0;
        mon.mon_data_in = '0;
        mon.mon_data_out = '0;
        mon.mon_wr_ack = 1'b1;
        mon.mon_overflow = 1'b0;
        mon.mon_underflow = 1'b0;
        mon.mon_full = 1'b0;
        mon.mon_almostfull = 1'b0;
        mon.mon_empty = 1'b0;
        mon.mon_almostempty = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        clear_fifo();
        clear_sb();
        rst = 1'b0;
    endtask

    typedef struct {
        bit           wr, rd;
        logic [W-1:0] din;
        bit           mrst_n, clr;
        logic [7:0]   fmask;
        logic [W-1:0] fdata;
        int           e_corr, e_err;
        logic [7:0]   e_sticky, e_code;
        logic [W-1:0] e_fexp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit wr, bit rd, logic [W-1:0] din, bit mrst_n, bit clr_i,
                                logic [7:0] fmask, logic [W-1:0] fdata, int e_corr, int e_err,
                                logic [7:0] e_sticky, logic [7:0] e_code, logic [W-1:0] e_fexp);
        vec_t v;
        v.wr = wr; v.rd = rd; v.din = din; v.mrst_n = mrst_n; v.clr = clr_i;
        v.fmask = fmask; v.fdata = fdata; v.e_corr = e_corr; v.e_err = e_err;
        v.e_sticky = e_sticky; v.e_code = e_code; v.e_fexp = e_fexp;
        return v;
    endfunction

    task automatic compare_outputs(input string tag, input int e_corr, input int e_err,
                                   input logic [7:0] e_sticky, input logic [7:0] e_code,
                                   input logic [W-1:0] e_fexp);
        check({tag, " correct_cnt"}, 32'(correct_cnt), 32'(e_corr));
        check({tag, " error_cnt"}, 32'(error_cnt), 32'(e_err));
        check({tag, " err_sticky"}, 32'(err_sticky), 32'(e_sticky));
`ifdef FIRST_ERR_CAPTURE_EN
        check({tag, " first_err_code"}, 32'(first_err_code), 32'(e_code));
        check({tag, " first_err_exp"}, 32'(first_err_exp), 32'(e_fexp));
`else
        if (e_code === 8'hxx || e_fexp === 'x) $display("note: unexpected X in table");
        check({tag, " first_err_code"}, 32'(first_err_code), 32'd0);
        check({tag, " first_err_exp"}, 32'(first_err_exp), 32'd0);
`endif
    endtask

    initial begin
        do_reset();

        // Fill: eight writes, then a ninth into a full FIFO.
        for (int k = 1; k <= 8; k++) tbl.push_back(mk(1, 0, W'(k), 1, 0, 0, 0, k, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 16'h0009, 1, 0, 0, 0, 9, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 10, 0, 0, 0, 0));
        // Write+read at count 8: only the read happens, overflow follows.
        tbl.push_back(mk(1, 1, 16'h000A, 1, 0, 0, 0, 11, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 12, 0, 0, 0, 0));
        // Drain the remaining seven.
        for (int k = 13; k <= 19; k++) tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0, k, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 20, 0, 0, 0, 0));
        // Write+read at count 0: only the write happens, underflow follows; pointers have wrapped.
        tbl.push_back(mk(1, 1, 16'h0011, 1, 0, 0, 0, 21, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 22, 0, 0, 0, 0));
        for (int k = 23; k <= 25; k++)
            tbl.push_back(mk(1, 1, W'(16'h0012 + k - 23), 1, 0, 0, 0, k, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0, 26, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 27, 0, 0, 0, 0));
        // Fault on the read that returns 0x0003.
        for (int k = 28; k <= 30; k++) tbl.push_back(mk(1, 0, W'(k - 27), 1, 0, 0, 0, k, 0, 0, 0, 0));
        for (int k = 31; k <= 33; k++) tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0, k, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 8'h01, 16'hBEEF, 33, 1, 8'h01, 8'h01, 16'h0003));
        // Observed reset at count 5, then an empty-model cycle.
        for (int k = 34; k <= 38; k++)
            tbl.push_back(mk(1, 0, W'(16'h0021 + k - 34), 1, 0, 0, 0, k, 1, 8'h01, 8'h01, 16'h0003));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 38, 1, 8'h01, 8'h01, 16'h0003));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 39, 1, 8'h01, 8'h01, 16'h0003));
        // clr, then clr with a fault that must be discarded.
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 8'h10, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0));
        // Fresh first error after clr, later error must not overwrite it.
        tbl.push_back(mk(0, 0, 0, 1, 0, 8'h40, 0, 1, 1, 8'h40, 8'h40, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 8'h80, 0, 1, 2, 8'hC0, 8'h40, 0));
        // data_out corrupted with no read outstanding: not compared.
        tbl.push_back(mk(0, 0, 0, 1, 0, 8'h01, 16'h1234, 2, 2, 8'hC0, 8'h40, 0));

        foreach (tbl[i]) begin
            step(tbl[i].wr, tbl[i].rd, tbl[i].din, tbl[i].mrst_n, tbl[i].clr,
                 tbl[i].fmask, tbl[i].fdata);
            compare_outputs($sformatf("vec%0d", i), tbl[i].e_corr, tbl[i].e_err,
                            tbl[i].e_sticky, tbl[i].e_code, tbl[i].e_fexp);
        end

        // Randomized traffic with alternating fill/drain bias, sparse resets, clears and faults.
        for (int i = 0; i < 800; i++) begin
            int           bias;
            bit           wr, rd, mrst_n, clr_i;
            logic [7:0]   fmask;
            logic [W-1:0] fdata;
            bias   = ((i / 60) % 2 == 0) ? 75 : 25;
            wr     = ($urandom_range(0, 99) < bias);
            rd     = ($urandom_range(0, 99) < 100 - bias);
            mrst_n = ($urandom_range(0, 69) != 0);
            clr_i  = ($urandom_range(0, 249) == 0);
            fmask  = '0;
            if ($urandom_range(0, 5) == 0) fmask = 8'(1 << $urandom_range(0, 7));
            if ($urandom_range(0, 29) == 0) fmask = 8'($urandom_range(0, 255));
            fdata  = r_dout ^ W'($urandom_range(1, 65535));
            step(wr, rd, W'($urandom), mrst_n, clr_i, fmask, fdata);
            compare_outputs($sformatf("rnd%0d", i), sb_corr, sb_err, sb_sticky, sb_code, sb_fexp);
        end

        // Reset again; the first edge after it is checked.
        do_reset();
        step(0, 0, 0, 1, 0, 8'h02, 0);
        compare_outputs("post_rst", 0, 1, 8'h02, 8'h02, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        compare_outputs("post_rst2", 1, 1, 8'h02, 8'h02, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_chk.md
FIFO_CHK -- requirements
Module: fifo_chk

Interface
REQ-001 Parameter FIFO_WIDTH, default 16, data width of the observed FIFO.
REQ-002 Parameter FIFO_DEPTH, default 8, depth of the observed FIFO, power of two, at least 4.
REQ-003 Parameter CNT_W, default 16, width of the pass and error counters.
REQ-004 clk  in  1  single clock; all logic updates on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset of the checker.
REQ-006 mon_rst_n  in  1  observed FIFO reset, active-low.
REQ-007 mon_wr_en, mon_rd_en  in  1 each  observed write and read requests.
REQ-008 mon_data_in  in  FIFO_WIDTH  observed write data.
REQ-009 mon_data_out  in  FIFO_WIDTH  observed read data.
REQ-010 mon_wr_ack, mon_overflow, mon_underflow  in  1 each  observed registered status.
REQ-011 mon_full, mon_almostfull, mon_empty, mon_almostempty  in  1 each  observed combinational flags.
REQ-012 clr  in  1  synchronous clear of counters and sticky flags only; the model is untouched.
REQ-013 correct_cnt, error_cnt  out  CNT_W each  number of checked cycles that passed or failed.
REQ-014 err_sticky  out  8  sticky mismatch bits: [0] data_out, [1] wr_ack, [2] overflow, [3] underflow, [4] full, [5] almostfull, [6] empty, [7] almostempty.
REQ-015 first_err_code  out  8  mismatch vector of the first failing cycle.
REQ-016 first_err_exp  out  FIFO_WIDTH  expected data_out at the first data mismatch.

Function
REQ-017 The reference model holds a FIFO_DEPTH x FIFO_WIDTH memory, write and read pointers of log2(FIFO_DEPTH) bits that wrap modulo FIFO_DEPTH, and an occupancy count from 0 to FIFO_DEPTH.
REQ-018 Write accepted = mon_wr_en and count != FIFO_DEPTH; read accepted = mon_rd_en and count != 0; both evaluated on the pre-edge count.
REQ-019 Simultaneous accepted write and read: count unchanged and both pointers advance; at count FIFO_DEPTH only the read occurs; at count 0 only the write occurs.
REQ-020 Predicted registered outputs (one-cycle latency): exp_wr_ack = write accepted; exp_overflow = mon_wr_en and full; exp_underflow = mon_rd_en and empty; exp_data = mem[rd_ptr] with exp_dvld = read accepted.
REQ-021 Predicted flags from the current count: full at FIFO_DEPTH, almostfull at FIFO_DEPTH-1, empty at 0, almostempty at 1.
REQ-022 Each edge runs a compare phase (sampled DUT outputs against the predictions held in model state) and then an update phase (model advanced with the sampled inputs).
REQ-023 Bit [0] is compared only when exp_dvld=1; all other bits are compared every checked cycle.
REQ-024 A checked cycle with a zero mismatch vector increments correct_cnt; otherwise it increments error_cnt and ORs the vector into err_sticky.
REQ-025 Both counters saturate at all-ones.
REQ-026 mon_rst_n=0 sampled: model count, pointers and predictions are cleared, no comparison is made, and counters hold; the following cycle is checked against the empty model.
REQ-027 clr=1: counters, err_sticky and first-error registers go to 0 that edge; the model keeps updating; a mismatch in the same cycle is discarded.

Reset
REQ-028 rst=1: correct_cnt, error_cnt, err_sticky, first_err_code, first_err_exp, count, pointers and all predictions are 0; memory contents are don't-care.
REQ-029 rst takes priority over mon_rst_n and clr; the first checked cycle is the edge after rst deasserts.

Configuration
REQ-030 With FIRST_ERR_CAPTURE_EN defined, first_err_code and first_err_exp load on the first failing cycle after reset or clr and then hold.
REQ-031 Without FIRST_ERR_CAPTURE_EN, first_err_code and first_err_exp are constant 0 and no capture registers are built.

Verification
REQ-032 Fill: 8 writes of 0x0001..0x0008 with no reads -> wr_ack=1 each; full=1 after the 8th write; error_cnt=0.
REQ-033 Overflow: a 9th write of 0x0009 while full -> overflow=1 next cycle; correct_cnt increments; count stays 8.
REQ-034 Drain and wrap: 8 reads and then 4 writes plus 4 reads -> data_out order 0x0001..0x0008; pointers wrap; error_cnt=0.
REQ-035 Simultaneous write and read at count 0 -> only the write is accepted, with underflow=1; at count 8 -> only the read is accepted, with overflow=1.
REQ-036 Fault injection: DUT data_out forced to 0xBEEF on a read expecting 0x0003 -> err_sticky[0]=1, error_cnt=1; with the macro, first_err_code=0x01 and first_err_exp=0x0003.
REQ-037 mon_rst_n pulsed low at count 5 -> model empties; next cycle expects empty=1; clr pulse zeroes both counters.
